// File: rtl/data_mem_if.sv
// Core-to-backing-store request/response bundle for data_mem_bridge.
// The misaligned flag exists only when DATA_MEM_ALIGN_CHECK_EN is defined.
interface data_mem_if #(
   parameter int unsigned ADDR_W = 32
) ();
   logic [ADDR_W-1:0]  mem_addr;
   logic [0:3][7:0]    mem_data_in;
   logic               mem_write_en;
   logic               mem_read_en;
   logic [0:3][7:0]    mem_data_out;
   logic               busy;
   logic               resp_valid;
   logic               req_dropped;
`ifdef DATA_MEM_ALIGN_CHECK_EN
   logic               misaligned;
`endif

   modport master (
      output mem_addr, mem_data_in, mem_write_en, mem_read_en,
      input  mem_data_out, busy, resp_valid, req_dropped
`ifdef DATA_MEM_ALIGN_CHECK_EN
      , input misaligned
`endif
   );

   modport slave (
      input  mem_addr, mem_data_in, mem_write_en, mem_read_en,
      output mem_data_out, busy, resp_valid, req_dropped
`ifdef DATA_MEM_ALIGN_CHECK_EN
      , output misaligned
`endif
   );
endinterface

// File: rtl/data_mem_bridge.sv
// Fixed-latency byte-lane word memory behind the core's memory port.
// Optional DATA_MEM_ALIGN_CHECK_EN suppresses and flags misaligned requests.
module data_mem_bridge #(
   parameter int unsigned LATENCY     = 5,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned ADDR_W      = 32
) (
   input  logic      clk,
   input  logic      rst,
   data_mem_if.slave bus
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
   typedef logic [0:3][7:0] lanes_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pend_q, pend_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             wr_q, wr_d;
   lanes_t           wdata_q, wdata_d;
   lanes_t           rdata_q, rdata_d;
   logic             busy_q, busy_d;
   logic             resp_q, resp_d;
   logic             drop_q, drop_d;
   logic             req_mis_q, req_mis_d;
   logic             mis_q, mis_d;
   logic             strobe_c;
   logic             complete_c;
   logic             mem_we_c;
   lanes_t           mem [DEPTH_WORDS];
   logic             unused_addr_bits;

   assign strobe_c = bus.mem_write_en | bus.mem_read_en;
   assign unused_addr_bits = ^{bus.mem_addr[ADDR_W-1:IDX_W+2], bus.mem_addr[1:0]};

   // Next-state, request latch and response generation
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pend_d     = 1'b0;
      idx_d      = idx_q;
      wr_d       = wr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      resp_d     = 1'b0;
      drop_d     = 1'b0;
      mis_d      = 1'b0;
      req_mis_d  = req_mis_q;
      mem_we_c   = 1'b0;

      // pend_q carries the single-cycle completion when LATENCY is 1
      complete_c = ((state_q == WAIT) && (cnt_q == '0)) || pend_q;

      if (complete_c) begin
         resp_d = 1'b1;
         if (req_mis_q) begin
            mis_d = 1'b1;
         end else if (wr_q) begin
            mem_we_c = 1'b1;
         end else begin
            rdata_d = mem[idx_q];
         end
      end

      case (state_q)
         IDLE: begin
            if (strobe_c) begin
               idx_d   = bus.mem_addr[IDX_W+1:2];
               wr_d    = bus.mem_write_en;
               wdata_d = bus.mem_data_in;
`ifdef DATA_MEM_ALIGN_CHECK_EN
               req_mis_d = (bus.mem_addr[1:0] != 2'b00);
`else
               req_mis_d = 1'b0;
`endif
               if (LATENCY == 1) begin
                  pend_d = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_LOAD;
               end
            end
         end
         WAIT: begin
            drop_d = strobe_c;
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // The acceptance cycle itself is not reported busy
      busy_d = (state_d == WAIT) && (cnt_d != CNT_LOAD);
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pend_q    <= 1'b0;
         idx_q     <= '0;
         wr_q      <= 1'b0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         busy_q    <= 1'b0;
         resp_q    <= 1'b0;
         drop_q    <= 1'b0;
         req_mis_q <= 1'b0;
         mis_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_q    <= pend_d;
         idx_q     <= idx_d;
         wr_q      <= wr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         busy_q    <= busy_d;
         resp_q    <= resp_d;
         drop_q    <= drop_d;
         req_mis_q <= req_mis_d;
         mis_q     <= mis_d;
      end
   end

   // Storage survives reset; a completion coinciding with reset is discarded
   always_ff @(posedge clk) begin
      if (mem_we_c && !rst) begin
         mem[idx_q] <= wdata_q;
      end
   end

   assign bus.mem_data_out = rdata_q;
   assign bus.busy         = busy_q;
   assign bus.resp_valid   = resp_q;
   assign bus.req_dropped  = drop_q;
`ifdef DATA_MEM_ALIGN_CHECK_EN
   assign bus.misaligned   = mis_q;
`else
   logic unused_mis;
   assign unused_mis = mis_q;
`endif

endmodule

// File: tb/tb_data_mem_bridge.sv
// Self-checking bench for data_mem_bridge: directed vector table, corner
// sequences and randomized traffic against a timeline-based reference model.
module tb_data_mem_bridge;

   localparam int unsigned LAT   = 5;
   localparam int unsigned DEPTH = 1024;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   data_mem_if #(.ADDR_W(32)) bus ();

   data_mem_bridge #(.LATENCY(LAT), .DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model: a request accepted at edge n completes at edge n+LAT
   logic [31:0] mm [DEPTH];
   bit          known [DEPTH];
   int          n = 0;
   bit          m_pend = 0;
   int          m_acc = 0;
   int          m_done = 0;
   bit          m_wr = 0;
   bit          m_mis = 0;
   int          m_idx = 0;
   logic [31:0] m_data = '0;
   logic [31:0] m_dout = '0;
   bit          m_dout_known = 0;
   bit          exp_busy = 0, exp_resp = 0, exp_drop = 0, exp_mis = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, n);
      end
   endtask

   task automatic model_edge(input logic r, input logic we, input logic re,
                             input logic [31:0] a, input logic [31:0] d);
      bit blocked;
      n++;
      exp_resp = 0;
      exp_drop = 0;
      exp_mis  = 0;
      if (r) begin
         m_pend       = 0;
         m_dout       = '0;
         m_dout_known = 1;
      end else begin
         blocked = m_pend && (LAT > 1);
         if (m_pend && n == m_done) begin
            m_pend   = 0;
            exp_resp = 1;
            if (m_mis) exp_mis = 1;
            else if (m_wr) begin
               mm[m_idx]    = m_data;
               known[m_idx] = 1;
            end else begin
               m_dout       = mm[m_idx];
               m_dout_known = known[m_idx];
            end
         end
         if (we || re) begin
            if (blocked) exp_drop = 1;
            else begin
               m_pend = 1;
               m_acc  = n;
               m_done = n + LAT;
               m_wr   = we;
               m_idx  = int'((a >> 2) % DEPTH);
               m_data = d;
`ifdef DATA_MEM_ALIGN_CHECK_EN
               m_mis  = (a % 4) != 0;
`else
               m_mis  = 0;
`endif
            end
         end
      end
      exp_busy = m_pend && (n >= m_acc + 1) && (n <= m_done - 1);
   endtask

   task automatic compare_model();
      check("busy", 32'(bus.busy), 32'(exp_busy));
      check("resp_valid", 32'(bus.resp_valid), 32'(exp_resp));
      check("req_dropped", 32'(bus.req_dropped), 32'(exp_drop));
      if (m_dout_known) check("mem_data_out", 32'(bus.mem_data_out), m_dout);
`ifdef DATA_MEM_ALIGN_CHECK_EN
      check("misaligned", 32'(bus.misaligned), 32'(exp_mis));
`endif
   endtask

   // Drive one cycle of inputs, clock it, then check against the model
   task automatic apply(input logic r, input logic we, input logic re,
                        input logic [31:0] a, input logic [31:0] d);
      rst              = r;
      bus.mem_write_en = we;
      bus.mem_read_en  = re;
      bus.mem_addr     = a;
      bus.mem_data_in  = d;
      @(posedge clk);
      model_edge(r, we, re, a, d);
      #1;
      compare_model();
   endtask

   task automatic wait_resp(input string name);
      bit got = 0;
      for (int i = 0; i < int'(LAT) + 4; i++) begin
         apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
         if (bus.resp_valid) begin
            got = 1;
            break;
         end
      end
      check(name, 32'(got), 32'd1);
   endtask

   typedef struct {
      logic        r, we, re;
      logic [31:0] addr, data;
      logic        busy, resp, drop;
      logic [31:0] dout;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic we, input logic re,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic b, input logic rv, input logic dr,
                               input logic [31:0] o);
      vec_t v;
      v.r = r; v.we = we; v.re = re; v.addr = a; v.data = d;
      v.busy = b; v.resp = rv; v.drop = dr; v.dout = o;
      return v;
   endfunction

   initial begin
      logic        r, we, re;
      logic [31:0] a, d;

      rst              = 1'b1;
      bus.mem_write_en = 1'b0;
      bus.mem_read_en  = 1'b0;
      bus.mem_addr     = '0;
      bus.mem_data_in  = '0;

      // Directed timeline: write 0x10, back-to-back read, drops during WAIT
      vecs.push_back(mk(1, 0, 0, 32'h00, 32'h0, 0, 0, 0, 32'h0));
      vecs.push_back(mk(0, 1, 0, 32'h10, 32'h11223344, 0, 0, 0, 32'h0));
      for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 32'h0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 32'h0));
      vecs.push_back(mk(0, 0, 1, 32'h10, 32'h0, 0, 0, 0, 32'h0));
      for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 32'h0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 32'h11223344));
      vecs.push_back(mk(0, 1, 0, 32'h20, 32'hAABBCCDD, 0, 0, 0, 32'h11223344));
      vecs.push_back(mk(0, 0, 1, 32'h10, 32'h0, 1, 0, 1, 32'h11223344));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 32'h11223344));
      vecs.push_back(mk(0, 0, 1, 32'h10, 32'h0, 1, 0, 1, 32'h11223344));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 32'h11223344));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 32'h11223344));
      vecs.push_back(mk(0, 0, 1, 32'h20, 32'h0, 0, 0, 0, 32'h11223344));
      for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 32'h11223344));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 32'hAABBCCDD));

      apply(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      foreach (vecs[i]) begin
         apply(vecs[i].r, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].data);
         check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].busy));
         check($sformatf("vec%0d_resp", i), 32'(bus.resp_valid), 32'(vecs[i].resp));
         check($sformatf("vec%0d_drop", i), 32'(bus.req_dropped), 32'(vecs[i].drop));
         check($sformatf("vec%0d_dout", i), 32'(bus.mem_data_out), vecs[i].dout);
      end

      // Both strobes at 0x1000: write wins, wraps to word 0, no drop
      apply(1'b0, 1'b1, 1'b1, 32'h1000, 32'h5A6B7C8D);
      check("both_no_drop", 32'(bus.req_dropped), 32'd0);
      wait_resp("both_resp_timeout");
      apply(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
      wait_resp("wrap_rd_timeout");
      check("wrap_rd_data", 32'(bus.mem_data_out), 32'h5A6B7C8D);

      // Reset two cycles into a write to 0x30 discards it
      apply(1'b0, 1'b1, 1'b0, 32'h30, 32'hCAFEF00D);
      wait_resp("pre_wr_timeout");
      apply(1'b0, 1'b1, 1'b0, 32'h30, 32'h01020304);
      apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      apply(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_dout", 32'(bus.mem_data_out), 32'h0);
      for (int i = 0; i < int'(LAT) + 2; i++) begin
         apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
         check("rst_no_resp", 32'(bus.resp_valid), 32'd0);
      end
      apply(1'b0, 1'b0, 1'b1, 32'h30, 32'h0);
      wait_resp("rst_rd_timeout");
      check("rst_rd_data", 32'(bus.mem_data_out), 32'hCAFEF00D);

`ifdef DATA_MEM_ALIGN_CHECK_EN
      // Misaligned write leaves word 4 intact and flags completion
      apply(1'b0, 1'b1, 1'b0, 32'h12, 32'hDEADBEEF);
      wait_resp("mis_resp_timeout");
      check("mis_flag", 32'(bus.misaligned), 32'd1);
      apply(1'b0, 1'b0, 1'b1, 32'h10, 32'h0);
      wait_resp("mis_rd_timeout");
      check("mis_flag_clear", 32'(bus.misaligned), 32'd0);
      check("mis_rd_data", 32'(bus.mem_data_out), 32'h11223344);
`endif

      // Randomized traffic with occasional resets, wrapped and aliased addresses
      for (int i = 0; i < 800; i++) begin
         r  = ($urandom_range(0, 79) == 0);
         we = ($urandom_range(0, 3) == 0);
         re = ($urandom_range(0, 2) == 0);
         a  = (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 3)) << 12);
`ifdef DATA_MEM_ALIGN_CHECK_EN
         if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
`endif
         d  = $urandom;
         apply(r, we, re, a, d);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
